// File: rtl/param_guarded_fifo.sv
// rtl/param_guarded_fifo.sv - guarded circular-buffer FIFO with flush and occupancy count
//
// Ports:
//   CLK, nRST          clock (rising edge), synchronous active-low reset
//   enq__ENA, enq_v    enqueue strobe and data; acted on only while enq__RDY=1
//   enq__RDY           room for one more entry (cnt != DEPTH)
//   deq__ENA           dequeue strobe; acted on only while deq__RDY=1
//   deq__RDY           at least one entry held (cnt != 0)
//   first, first__RDY  head-of-queue data (zero when empty) and its valid flag
//   clear__ENA         flush pointers and count; wins over enq/deq in the same cycle
//   count              occupancy 0..DEPTH
//   almost_full        count >= DEPTH-1
module param_guarded_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enq__ENA,
    input  logic [WIDTH-1:0] enq_v,
    output logic             enq__RDY,
    input  logic             deq__ENA,
    output logic             deq__RDY,
    output logic [WIDTH-1:0] first,
    output logic             first__RDY,
    input  logic             clear__ENA,
    output logic [CW-1:0]    count,
    output logic             almost_full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [CW-1:0] ALMOST_CNT = CW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic not_full;
    logic not_empty;
    logic do_enq;
    logic do_deq;
    logic mem_we;

    // Ready flags come from registered state only, so a full FIFO never
    // accepts an enqueue on the strength of a same-cycle dequeue, and an
    // empty FIFO never forwards enq_v straight to the dequeue side.
    assign not_full  = (cnt_q != FULL_CNT);
    assign not_empty = (cnt_q != '0);

    assign do_enq = enq__ENA & not_full;
    assign do_deq = deq__ENA & not_empty;

    // Clear and reset both suppress the write so a flushed cycle leaves no trace.
    assign mem_we = do_enq & ~clear__ENA & nRST;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (clear__ENA) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            // Pointers wrap by natural AW-bit overflow (DEPTH is a power of two).
            if (do_enq) wptr_d = wptr_q + AW'(1);
            if (do_deq) rptr_d = rptr_q + AW'(1);
            if (do_enq && !do_deq) cnt_d = cnt_q + CW'(1);
            else if (do_deq && !do_enq) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is deliberately not reset; the head mux below hides stale
    // or uninitialised contents whenever the FIFO is empty.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[wptr_q] <= enq_v;
        end
    end

    assign enq__RDY    = not_full;
    assign deq__RDY    = not_empty;
    assign first__RDY  = not_empty;
    assign first       = not_empty ? mem_q[rptr_q] : '0;
    assign count       = cnt_q;
    assign almost_full = (cnt_q >= ALMOST_CNT);

endmodule

// File: tb/tb_param_guarded_fifo.sv
// tb/tb_param_guarded_fifo.sv - directed vector bench for param_guarded_fifo
module tb_param_guarded_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NV    = 27;

    logic             CLK = 1'b0;
    logic             nRST;
    logic             enq__ENA;
    logic [WIDTH-1:0] enq_v;
    logic             enq__RDY;
    logic             deq__ENA;
    logic             deq__RDY;
    logic [WIDTH-1:0] first;
    logic             first__RDY;
    logic             clear__ENA;
    logic [CW-1:0]    count;
    logic             almost_full;

    int total = 0;
    int bad   = 0;

    param_guarded_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .nRST(nRST),
        .enq__ENA(enq__ENA),
        .enq_v(enq_v),
        .enq__RDY(enq__RDY),
        .deq__ENA(deq__ENA),
        .deq__RDY(deq__RDY),
        .first(first),
        .first__RDY(first__RDY),
        .clear__ENA(clear__ENA),
        .count(count),
        .almost_full(almost_full)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst_n;
        logic        enq;
        logic        deq;
        logic        clr;
        logic [31:0] data;
        int          e_count;
        logic        e_erdy;
        logic        e_drdy;
        logic [31:0] e_first;
        logic        e_af;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(logic r, logic e, logic d, logic c, logic [31:0] dat,
                                int ec, logic er, logic dr, logic [31:0] ef, logic af);
        vec_t v;
        v.rst_n = r; v.enq = e; v.deq = d; v.clr = c; v.data = dat;
        v.e_count = ec; v.e_erdy = er; v.e_drdy = dr; v.e_first = ef; v.e_af = af;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        // rst  enq deq clr data        count erdy drdy first      af
        vecs[0]  = mk(0, 0, 0, 0, 32'h0,  0, 1, 0, 32'h0,  0);
        vecs[1]  = mk(1, 1, 0, 0, 32'h11, 1, 1, 1, 32'h11, 0);
        vecs[2]  = mk(1, 1, 0, 0, 32'h22, 2, 1, 1, 32'h11, 0);
        vecs[3]  = mk(1, 1, 0, 0, 32'h33, 3, 1, 1, 32'h11, 1);
        vecs[4]  = mk(1, 1, 0, 0, 32'h44, 4, 0, 1, 32'h11, 1);
        vecs[5]  = mk(1, 1, 1, 0, 32'h55, 3, 1, 1, 32'h22, 1);
        vecs[6]  = mk(1, 0, 0, 0, 32'h0,  3, 1, 1, 32'h22, 1);
        vecs[7]  = mk(1, 0, 1, 0, 32'h0,  2, 1, 1, 32'h33, 0);
        vecs[8]  = mk(1, 0, 1, 0, 32'h0,  1, 1, 1, 32'h44, 0);
        vecs[9]  = mk(1, 0, 1, 0, 32'h0,  0, 1, 0, 32'h0,  0);
        vecs[10] = mk(1, 0, 1, 0, 32'h0,  0, 1, 0, 32'h0,  0);
        vecs[11] = mk(1, 1, 1, 0, 32'hA5, 1, 1, 1, 32'hA5, 0);
        vecs[12] = mk(1, 0, 1, 0, 32'h0,  0, 1, 0, 32'h0,  0);
        vecs[13] = mk(1, 1, 0, 0, 32'h1,  1, 1, 1, 32'h1,  0);
        vecs[14] = mk(1, 1, 0, 0, 32'h2,  2, 1, 1, 32'h1,  0);
        vecs[15] = mk(1, 1, 0, 0, 32'h3,  3, 1, 1, 32'h1,  1);
        vecs[16] = mk(1, 1, 0, 1, 32'h4,  0, 1, 0, 32'h0,  0);
        vecs[17] = mk(1, 1, 0, 0, 32'h6,  1, 1, 1, 32'h6,  0);
        vecs[18] = mk(1, 1, 0, 0, 32'h8,  2, 1, 1, 32'h6,  0);
        vecs[19] = mk(0, 1, 1, 0, 32'h9,  0, 1, 0, 32'h0,  0);
        vecs[20] = mk(1, 1, 0, 0, 32'h7,  1, 1, 1, 32'h7,  0);
        vecs[21] = mk(1, 1, 0, 0, 32'h1,  2, 1, 1, 32'h7,  0);
        vecs[22] = mk(1, 1, 0, 0, 32'h2,  3, 1, 1, 32'h7,  1);
        vecs[23] = mk(1, 1, 0, 0, 32'h3,  4, 0, 1, 32'h7,  1);
        vecs[24] = mk(1, 1, 0, 0, 32'h4,  4, 0, 1, 32'h7,  1);
        vecs[25] = mk(0, 0, 0, 0, 32'h0,  0, 1, 0, 32'h0,  0);
        vecs[26] = mk(1, 0, 1, 0, 32'h0,  0, 1, 0, 32'h0,  0);

        nRST = 1'b0; enq__ENA = 1'b0; deq__ENA = 1'b0; clear__ENA = 1'b0; enq_v = '0;

        for (int i = 0; i < NV; i++) begin
            @(negedge CLK);
            nRST       = vecs[i].rst_n;
            enq__ENA   = vecs[i].enq;
            deq__ENA   = vecs[i].deq;
            clear__ENA = vecs[i].clr;
            enq_v      = vecs[i].data;
            @(posedge CLK);
            #1;
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_count));
            chk($sformatf("v%0d enq_rdy", i), 32'(enq__RDY), 32'(vecs[i].e_erdy));
            chk($sformatf("v%0d deq_rdy", i), 32'(deq__RDY), 32'(vecs[i].e_drdy));
            chk($sformatf("v%0d first_rdy", i), 32'(first__RDY), 32'(vecs[i].e_drdy));
            chk($sformatf("v%0d first", i), first, vecs[i].e_first);
            chk($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vecs[i].e_af));
        end

        // Wrap: 0..9 streamed through with overlapping enq/deq pairs.
        @(negedge CLK);
        nRST = 1'b1; clear__ENA = 1'b0;
        enq__ENA = 1'b1; deq__ENA = 1'b0; enq_v = 32'd0;
        for (int i = 1; i < 10; i++) begin
            @(negedge CLK);
            chk($sformatf("wrap head %0d", i - 1), first, 32'(i - 1));
            total++;
            if (count > CW'(2)) begin
                bad++;
                $display("FAIL wrap count %0d: got %0d expected <=2", i, count);
            end
            enq__ENA = 1'b1; deq__ENA = 1'b1; enq_v = 32'(i);
        end
        @(negedge CLK);
        chk("wrap head 9", first, 32'd9);
        enq__ENA = 1'b0; deq__ENA = 1'b1;
        @(posedge CLK);
        #1;
        chk("wrap final count", 32'(count), 32'd0);
        chk("wrap final first", first, 32'd0);

        // Clear alone from a non-empty FIFO, then refill to confirm pointers restart cleanly.
        @(negedge CLK);
        deq__ENA = 1'b0; enq__ENA = 1'b1; enq_v = 32'hBEEF;
        @(negedge CLK);
        enq__ENA = 1'b0; clear__ENA = 1'b1;
        @(posedge CLK);
        #1;
        chk("clear count", 32'(count), 32'd0);
        chk("clear first_rdy", 32'(first__RDY), 32'd0);
        @(negedge CLK);
        clear__ENA = 1'b0; enq__ENA = 1'b1; enq_v = 32'hCAFE;
        @(posedge CLK);
        #1;
        chk("post-clear first", first, 32'hCAFE);
        chk("post-clear count", 32'(count), 32'd1);
        @(negedge CLK);
        enq__ENA = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
